// File: rtl/pa_pkg.sv
// Shared processor-architecture constants: register file geometry and the
// hardwired zero register index, used by decode, writeback and the register file.
package pa_pkg;

    localparam int PA_WIDTH = 32;
    localparam int PA_DEPTH = 32;
    localparam int REG_ZERO = 0;

    typedef logic [$clog2(PA_DEPTH)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_busy.sv
// Busy scoreboard for the register file: one pending-producer bit per register,
// issue-set beats writeback-clear, with optional same-cycle clear forwarding.
module reg_file_busy
    import pa_pkg::*;
#(
    parameter int DEPTH   = PA_DEPTH,
    parameter int R0_ZERO = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic          ra_busy,
    input  logic [AW-1:0] rb_addr,
    output logic          rb_busy,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          busy_set,
    input  logic [AW-1:0] busy_addr
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (R0_ZERO != 0) && (addr == AW'(REG_ZERO));
    endfunction

    // Clear is applied first so a same-address set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (wr_en)
            busy_d[wr_addr] = 1'b0;
        if (busy_set && !is_zero_reg(busy_addr))
            busy_d[busy_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    function automatic logic read_busy(input logic [AW-1:0] addr);
        logic cleared_now;
        cleared_now = (BYPASS != 0) && rst_n && wr_en && (wr_addr == addr)
                      && !(busy_set && (busy_addr == addr));
        if (is_zero_reg(addr) || cleared_now)
            return 1'b0;
        return busy_q[addr];
    endfunction

    assign ra_busy = read_busy(ra_addr);
    assign rb_busy = read_busy(rb_addr);

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with optional write forwarding,
// hardwired zero register and a per-register busy scoreboard.
module reg_file
    import pa_pkg::*;
#(
    parameter int WIDTH   = PA_WIDTH,
    parameter int DEPTH   = PA_DEPTH,
    parameter int R0_ZERO = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic             ra_busy,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic             rb_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr
);

    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (R0_ZERO != 0) && (addr == AW'(REG_ZERO));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en && !is_zero_reg(wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Forwarding is suppressed during reset so outputs show stored state.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        if (is_zero_reg(addr))
            return '0;
        if ((BYPASS != 0) && rst_n && wr_en && (wr_addr == addr))
            return wr_data;
        return mem[addr];
    endfunction

    assign ra_data = read_port(ra_addr);
    assign rb_data = read_port(rb_addr);

    reg_file_busy #(
        .DEPTH   (DEPTH),
        .R0_ZERO (R0_ZERO),
        .BYPASS  (BYPASS)
    ) u_busy (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr   (ra_addr),
        .ra_busy   (ra_busy),
        .rb_addr   (rb_addr),
        .rb_busy   (rb_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy_set  (busy_set),
        .busy_addr (busy_addr)
    );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: three configurations driven in lockstep and compared
// against an array-based model of register contents and busy bits.
module tb_reg_file;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int N  = 3;

    // Configurations: 0 = zero reg + bypass, 1 = zero reg no bypass, 2 = bypass only
    localparam bit CFG_R0 [N] = '{1'b1, 1'b1, 1'b0};
    localparam bit CFG_BP [N] = '{1'b1, 1'b0, 1'b1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ra_addr, rb_addr, wr_addr, busy_addr;
    logic [W-1:0]  wr_data;
    logic          wr_en, busy_set;

    logic [W-1:0]  ra_data_v [N];
    logic [W-1:0]  rb_data_v [N];
    logic          ra_busy_v [N];
    logic          rb_busy_v [N];

    logic [W-1:0]  m_mem  [N][D];
    bit            m_busy [N][D];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file #(.WIDTH(W), .DEPTH(D), .R0_ZERO(1), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data_v[0]), .ra_busy(ra_busy_v[0]),
        .rb_addr(rb_addr), .rb_data(rb_data_v[0]), .rb_busy(rb_busy_v[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    reg_file #(.WIDTH(W), .DEPTH(D), .R0_ZERO(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data_v[1]), .ra_busy(ra_busy_v[1]),
        .rb_addr(rb_addr), .rb_data(rb_data_v[1]), .rb_busy(rb_busy_v[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    reg_file #(.WIDTH(W), .DEPTH(D), .R0_ZERO(0), .BYPASS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .ra_data(ra_data_v[2]), .ra_busy(ra_busy_v[2]),
        .rb_addr(rb_addr), .rb_data(rb_data_v[2]), .rb_busy(rb_busy_v[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_data(input int k, input logic [AW-1:0] a);
        if (CFG_R0[k] && a == 0) return '0;
        if (CFG_BP[k] && rst_n && wr_en && wr_addr == a) return wr_data;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
        if (CFG_R0[k] && a == 0) return 1'b0;
        if (CFG_BP[k] && rst_n && wr_en && wr_addr == a && !(busy_set && busy_addr == a))
            return 1'b0;
        return m_busy[k][a];
    endfunction

    task automatic check_now(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_c%0d_ra_data", tag, k), ra_data_v[k], exp_data(k, ra_addr));
            chk($sformatf("%s_c%0d_rb_data", tag, k), rb_data_v[k], exp_data(k, rb_addr));
            chk($sformatf("%s_c%0d_ra_busy", tag, k), W'(ra_busy_v[k]), W'(exp_busy(k, ra_addr)));
            chk($sformatf("%s_c%0d_rb_busy", tag, k), W'(rb_busy_v[k]), W'(exp_busy(k, rb_addr)));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                for (int i = 0; i < D; i++) begin
                    m_mem[k][i]  = '0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (wr_en) begin
                    if (!(CFG_R0[k] && wr_addr == 0)) m_mem[k][wr_addr] = wr_data;
                    m_busy[k][wr_addr] = 1'b0;
                end
                if (busy_set && !(CFG_R0[k] && busy_addr == 0))
                    m_busy[k][busy_addr] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_now(tag);
        advance();
    endtask

    task automatic drive(input logic rst, input logic we, input int wa, input logic [W-1:0] wd,
                         input logic bs, input int ba, input int aa, input int ab);
        rst_n     = rst;
        wr_en     = we;
        wr_addr   = AW'(wa);
        wr_data   = wd;
        busy_set  = bs;
        busy_addr = AW'(ba);
        ra_addr   = AW'(aa);
        rb_addr   = AW'(ab);
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            for (int i = 0; i < D; i++) begin
                m_mem[k][i]  = 'x;
                m_busy[k][i] = 1'b0;
            end
        drive(0, 0, 0, '0, 0, 0, 0, 0);
        advance();
        step("rst");

        // Reset clears a written register
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);  step("wr_r5");
        drive(0, 0, 0, '0, 0, 0, 5, 5);             step("rst_r5");
        drive(1, 0, 0, '0, 0, 0, 5, 5);
        @(negedge clk);
        check_now("after_rst");
        chk("reset_r5_data", ra_data_v[0], '0);
        chk("reset_r5_busy", W'(ra_busy_v[0]), '0);
        advance();

        // Write/read and zero register
        drive(1, 1, 7, 32'h12345678, 0, 0, 7, 0);  step("wr_r7");
        drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 7, 0);  step("wr_r0");
        drive(1, 0, 0, '0, 0, 0, 7, 0);
        @(negedge clk);
        check_now("rd_r7_r0");
        chk("rd_r7", ra_data_v[0], 32'h12345678);
        chk("rd_r0_zero", rb_data_v[0], '0);
        chk("rd_r0_nozero", rb_data_v[2], 32'hFFFFFFFF);
        advance();

        // Write forwarding versus registered visibility
        drive(1, 1, 3, 32'h11111111, 0, 0, 3, 3);  step("wr_r3_old");
        drive(1, 1, 3, 32'hA5A5A5A5, 0, 0, 3, 3);
        @(negedge clk);
        check_now("byp_r3");
        chk("byp_same_cycle", ra_data_v[0], 32'hA5A5A5A5);
        chk("nobyp_old_value", ra_data_v[1], 32'h11111111);
        advance();
        drive(1, 0, 0, '0, 0, 0, 3, 3);
        @(negedge clk);
        check_now("nobyp_r3_next");
        chk("nobyp_next_cycle", ra_data_v[1], 32'hA5A5A5A5);
        advance();

        // Scoreboard set then clear
        drive(1, 0, 0, '0, 1, 9, 0, 9);            step("set_r9");
        drive(1, 0, 0, '0, 0, 0, 0, 9);
        @(negedge clk);
        check_now("busy_r9");
        chk("busy_r9_set", W'(rb_busy_v[0]), 32'd1);
        advance();
        drive(1, 1, 9, 32'h99, 0, 0, 0, 9);
        @(negedge clk);
        check_now("clr_r9");
        chk("busy_byp_clear", W'(rb_busy_v[0]), '0);
        chk("busy_nobyp_still", W'(rb_busy_v[1]), 32'd1);
        advance();
        drive(1, 0, 0, '0, 0, 0, 0, 9);
        @(negedge clk);
        check_now("clr_r9_next");
        chk("busy_nobyp_clear", W'(rb_busy_v[1]), '0);
        advance();

        // Set and clear colliding on one register
        drive(1, 0, 0, '0, 1, 4, 4, 0);            step("set_r4");
        drive(1, 1, 4, 32'h44, 1, 4, 4, 0);
        @(negedge clk);
        check_now("collide_r4");
        chk("collide_busy", W'(ra_busy_v[0]), 32'd1);
        chk("collide_data", ra_data_v[0], 32'h44);
        advance();
        drive(1, 0, 0, '0, 0, 0, 4, 0);
        @(negedge clk);
        check_now("collide_r4_next");
        chk("collide_busy_next", W'(ra_busy_v[0]), 32'd1);
        chk("collide_data_next", ra_data_v[1], 32'h44);
        advance();

        // Reset overrides write and set in the same cycle
        drive(1, 1, 2, 32'h22, 0, 0, 2, 2);        step("pre_r2");
        drive(0, 1, 2, 32'h55, 1, 2, 2, 2);        step("rst_prio");
        drive(1, 0, 0, '0, 0, 0, 2, 2);
        @(negedge clk);
        check_now("rst_prio_after");
        chk("rst_prio_data", ra_data_v[0], '0);
        chk("rst_prio_busy", W'(ra_busy_v[0]), '0);
        advance();

        // Random traffic; narrow address range half the time to force collisions
        for (int n = 0; n < 3000; n++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 3 : D - 1;
            drive(($urandom_range(0, 49) != 0),
                  $urandom_range(0, 1),
                  $urandom_range(0, lim),
                  $urandom(),
                  $urandom_range(0, 1),
                  $urandom_range(0, lim),
                  $urandom_range(0, lim),
                  $urandom_range(0, lim));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
